// File: rtl/dsm_param_mod.sv
// Parametrised delta-sigma modulator: 1st/2nd-order loop, 2/3-level quantiser,
// LFSR dither, sample handshake with oversampling counter, sticky status.
module dsm_param_mod #(
   parameter int          W         = 15,
   parameter int          OSR       = 64,
   parameter int          AW        = W + 4,
   parameter int          DITH_BITS = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         order2,
   input  logic         three_level,
   input  logic         dith_en,
   input  logic         clear_status,
   input  logic [W-1:0] vin,
   input  logic         vin_valid,
   output logic         vin_ready,
   output logic [1:0]   pwm,
   output logic         overload,
   output logic         underrun
);

   localparam int SW = AW + 2;
   localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

   localparam logic signed [SW-1:0] VREF = SW'(2 ** (W - 2));
   localparam logic signed [SW-1:0] VNEG = -VREF;
   localparam logic signed [SW-1:0] TH   = SW'(2 ** (W - 3));
   localparam logic signed [SW-1:0] THN  = -TH;
   localparam logic signed [SW-1:0] IMAX = SW'(2 ** (AW - 1) - 1);
   localparam logic signed [SW-1:0] IMIN = -IMAX;
   localparam logic [15:0]          MASK = 16'hB400;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [W-1:0]         x_q, x_d;
   logic signed [AW-1:0] i1_q, i1_d;
   logic signed [AW-1:0] i2_q, i2_d;
   logic [1:0]           pwm_q, pwm_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic                 ovl_q, ovl_d;
   logic                 unr_q, unr_d;

   logic signed [SW-1:0] x_s, i1_s, i2_s, fb_s, d_s;
   logic signed [SW-1:0] sum1, sum2, q_s;
   logic signed [AW-1:0] sat1, sat2;
   logic                 clip1, clip2, wrap, accept;
   logic [1:0]           qpwm;
   logic [15:0]          lfsr_nxt;

   assign x_s  = SW'(signed'(x_q));
   assign i1_s = SW'(i1_q);
   assign i2_s = SW'(i2_q);
   assign d_s  = dith_en ? SW'(signed'(lfsr_q[15:16-DITH_BITS])) : '0;

   always_comb begin
      fb_s = '0;
      if (pwm_q == 2'b01) fb_s = VREF;
      else if (pwm_q == 2'b11) fb_s = VNEG;
   end

   assign sum1  = i1_s + x_s - fb_s;
   assign sum2  = i2_s + i1_s - fb_s;
   assign clip1 = (sum1 > IMAX) || (sum1 < IMIN);
   assign clip2 = (sum2 > IMAX) || (sum2 < IMIN);

   always_comb begin
      sat1 = sum1[AW-1:0];
      if (sum1 > IMAX) sat1 = IMAX[AW-1:0];
      else if (sum1 < IMIN) sat1 = IMIN[AW-1:0];
      sat2 = sum2[AW-1:0];
      if (sum2 > IMAX) sat2 = IMAX[AW-1:0];
      else if (sum2 < IMIN) sat2 = IMIN[AW-1:0];
   end

   assign q_s = (order2 ? i2_s : i1_s) + d_s;

   always_comb begin
      qpwm = 2'b00;
      if (three_level) begin
         if (q_s > TH) qpwm = 2'b01;
         else if (q_s < THN) qpwm = 2'b11;
      end else begin
         qpwm = q_s[SW-1] ? 2'b11 : 2'b01;
      end
   end

   assign lfsr_nxt  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
   assign wrap      = (cnt_q == CW'(OSR - 1));
   assign vin_ready = ~reset & enable & ((state_q == IDLE) | wrap);
   assign accept    = vin_valid & vin_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      pwm_d   = pwm_q;
      lfsr_d  = lfsr_q;
      ovl_d   = ovl_q & ~clear_status;
      unr_d   = unr_q & ~clear_status;
      if (state_q == IDLE || !enable) begin
         pwm_d   = 2'b00;
         i1_d    = '0;
         i2_d    = '0;
         cnt_d   = '0;
         state_d = IDLE;
         if (state_q == IDLE && accept) begin
            x_d     = vin;
            state_d = RUN;
         end
      end else begin
         cnt_d  = wrap ? '0 : cnt_q + CW'(1);
         i1_d   = sat1;
         pwm_d  = qpwm;
         lfsr_d = lfsr_nxt;
         if (accept) x_d = vin;
         if (wrap && !accept) unr_d = 1'b1;
         // i2 freezes in 1st-order mode so it can resume later
         if (order2) i2_d = sat2;
         if (clip1 || (order2 && clip2)) ovl_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         i1_q    <= '0;
         i2_q    <= '0;
         pwm_q   <= 2'b00;
         lfsr_q  <= LFSR_SEED;
         ovl_q   <= 1'b0;
         unr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
         pwm_q   <= pwm_d;
         lfsr_q  <= lfsr_d;
         ovl_q   <= ovl_d;
         unr_q   <= unr_d;
      end
   end

   assign pwm      = pwm_q;
   assign overload = ovl_q;
   assign underrun = unr_q;

endmodule

// File: tb/tb_dsm_param_mod.sv
// Bench for dsm_param_mod: directed phases plus random traffic, all checked
// against an integer-arithmetic loop model kept in lockstep with the DUT.
module tb_dsm_param_mod;

   localparam int W    = 15;
   localparam int OSR  = 4;
   localparam int AW   = W + 4;
   localparam int DB   = 4;
   localparam int VREF = 2 ** (W - 2);
   localparam int TH   = 2 ** (W - 3);
   localparam int IMAX = 2 ** (AW - 1) - 1;
   localparam int SEED = 'hACE1;

   logic         clock = 1'b0;
   logic         reset, enable, order2, three_level, dith_en, clear_status;
   logic [W-1:0] vin;
   logic         vin_valid, vin_ready, overload, underrun;
   logic [1:0]   pwm;

   int n_assert = 0;
   int n_fail   = 0;

   bit m_run, m_ovl, m_unr;
   int m_cnt, m_x, m_i1, m_i2, m_lvl, m_lfsr;

   dsm_param_mod #(
      .W(W), .OSR(OSR), .AW(AW), .DITH_BITS(DB), .LFSR_SEED(16'hACE1)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .order2(order2),
      .three_level(three_level), .dith_en(dith_en),
      .clear_status(clear_status), .vin(vin), .vin_valid(vin_valid),
      .vin_ready(vin_ready), .pwm(pwm), .overload(overload),
      .underrun(underrun)
   );

   always #5 clock = ~clock;

   task automatic chk(string tag, logic signed [63:0] obs,
                      logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(int v, output bit c);
      c = (v > IMAX) || (v < -IMAX);
      if (v > IMAX) return IMAX;
      if (v < -IMAX) return -IMAX;
      return v;
   endfunction

   function automatic int sx(logic [W-1:0] v);
      int s = int'(v);
      if (s >= 2 ** (W - 1)) s -= 2 ** W;
      return s;
   endfunction

   function automatic int dither(int l);
      int v = (l >> (16 - DB)) & (2 ** DB - 1);
      if (v >= 2 ** (DB - 1)) v -= 2 ** DB;
      return v;
   endfunction

   function automatic int enc(int lvl);
      if (lvl > 0) return 1;
      if (lvl < 0) return 3;
      return 0;
   endfunction

   function automatic bit m_ready();
      if (reset) return 1'b0;
      if (!m_run) return enable;
      return enable && (m_cnt == OSR - 1);
   endfunction

   task automatic model_step();
      bit acc, c1, c2, wrap;
      int fb, q, n1, n2;
      if (reset) begin
         m_run = 0; m_cnt = 0; m_x = 0; m_i1 = 0; m_i2 = 0;
         m_lvl = 0; m_lfsr = SEED; m_ovl = 0; m_unr = 0;
         return;
      end
      acc = vin_valid && m_ready();
      c1 = 0; c2 = 0; wrap = 0;
      if (!m_run || !enable) begin
         m_lvl = 0; m_i1 = 0; m_i2 = 0; m_cnt = 0;
         if (!m_run && acc) begin
            m_x = sx(vin);
            m_run = 1;
         end else begin
            m_run = 0;
         end
      end else begin
         fb = m_lvl * VREF;
         q  = (order2 ? m_i2 : m_i1) + (dith_en ? dither(m_lfsr) : 0);
         n1 = clamp(m_i1 + m_x - fb, c1);
         n2 = clamp(m_i2 + m_i1 - fb, c2);
         if (!order2) begin
            n2 = m_i2;
            c2 = 0;
         end
         m_i1 = n1;
         m_i2 = n2;
         if (three_level) m_lvl = (q > TH) ? 1 : ((q < -TH) ? -1 : 0);
         else m_lvl = (q >= 0) ? 1 : -1;
         wrap = (m_cnt == OSR - 1);
         m_cnt = wrap ? 0 : m_cnt + 1;
         if (acc) m_x = sx(vin);
         m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr & 1) != 0 ? 'hB400 : 0);
      end
      m_ovl = c1 || c2 || (m_ovl && !clear_status);
      m_unr = (wrap && !acc) || (m_unr && !clear_status);
   endtask

   task automatic tick();
      #1;
      chk("vin_ready", vin_ready, m_ready());
      model_step();
      @(posedge clock);
      #1;
      chk("pwm", pwm, enc(m_lvl));
      chk("overload", overload, m_ovl);
      chk("underrun", underrun, m_unr);
      chk("lfsr", dut.lfsr_q, m_lfsr);
   endtask

   task automatic run_n(int n, output int diff, output int mdiff,
                        output int nz);
      diff = 0; mdiff = 0; nz = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (pwm == 2'b01) diff++;
         if (pwm == 2'b11) diff--;
         if (pwm != 2'b00) nz++;
         mdiff += m_lvl;
      end
   endtask

   task automatic go_idle();
      enable = 0;
      clear_status = 1;
      tick();
      clear_status = 0;
      enable = 1;
   endtask

   initial begin
      int diff, mdiff, nz, k;
      reset = 1; enable = 1; order2 = 0; three_level = 1; dith_en = 0;
      clear_status = 0; vin = '0; vin_valid = 1;

      for (int i = 0; i < 3; i++) tick();
      chk("rst_pwm", pwm, 0);
      chk("rst_ready", vin_ready, 0);
      chk("rst_overload", overload, 0);
      chk("rst_underrun", underrun, 0);
      reset = 0;
      #1;
      chk("ready_after_rst", vin_ready, 1);

      run_n(1000, diff, mdiff, nz);
      chk("zero_in_nonzero_pwm", nz, 0);
      chk("zero_in_overload", overload, 0);

      go_idle();
      vin = W'(VREF / 2);
      run_n(4096, diff, mdiff, nz);
      n_assert++;
      assert (diff >= 2046 && diff <= 2050) else begin
         n_fail++;
         $error("FAIL dc1_mean: observed %0d, expected 2048+-2", diff);
      end

      go_idle();
      order2 = 1;
      run_n(4096, diff, mdiff, nz);
      chk("dc2_mean", diff, mdiff);

      go_idle();
      order2 = 0; vin = W'(100);
      tick();
      for (int j = 0; j < 12; j++) begin
         chk("hs_ready", vin_ready, (j % 4) == 3);
         tick();
      end
      vin_valid = 0; vin = W'(555);
      for (int j = 0; j < 3; j++) tick();
      chk("underrun_before_wrap", underrun, 0);
      tick();
      chk("underrun_set", underrun, 1);
      chk("x_held", dut.x_q, 100);
      clear_status = 1;
      tick();
      clear_status = 0;
      chk("underrun_clr", underrun, 0);

      go_idle();
      vin = W'(16383); three_level = 0; vin_valid = 1;
      k = 0;
      while (k < 43 && overload !== 1'b1) begin
         tick();
         k++;
      end
      chk("ovl_within_43", overload, 1);
      clear_status = 1;
      tick();
      clear_status = 0;
      chk("ovl_sticky", overload, 1);

      go_idle();
      vin = '0; three_level = 1; dith_en = 1;
      run_n(100, diff, mdiff, nz);
      chk("dither_nonzero_pwm", nz, 0);

      for (int s = 0; s < 5; s++) begin
         enable = 0;
         tick();
         order2 = 1'($urandom);
         three_level = 1'($urandom);
         dith_en = 1'($urandom);
         enable = 1;
         for (int i = 0; i < 300; i++) begin
            vin_valid = ($urandom % 4) != 0;
            vin = W'(int'($urandom_range(0, 16383)) - 8192);
            clear_status = ($urandom % 16) == 0;
            enable = ($urandom % 100) != 0;
            tick();
         end
         clear_status = 0;
      end

      enable = 1; vin_valid = 1; vin = W'(300);
      for (int i = 0; i < 10; i++) tick();
      reset = 1;
      tick();
      chk("lfsr_reseed", dut.lfsr_q, SEED);
      chk("reset_pwm", pwm, 0);
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
